aes_mode_ctrl: RTL
==================

Name: aes_mode_ctrl

Overview:
Parametrised block-cipher mode controller that sits between a stream-style data interface and the team's iterative AES-128 core. It adds ECB, CBC and CTR chaining, encrypt/decrypt selection and valid/ready flow control on both sides. It also adds a completion timeout. It drives the core through its start/done pulse interface and owns all chaining state (IV/chain register, counter block).

Parameters:
BLOCK_W, 128, block and key width in bits; must be 128 for AES.
CTR_W, 32, number of low-order counter bits incremented in CTR mode (1..BLOCK_W).
MAX_WAIT, 64, maximum cycles from core_start to core_done before timeout (≥ core latency + margin).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous reset, active-low.
cfg_load  in  1  pulse: latch cfg_* and (re)initialise the chain/counter.
cfg_mode  in  2  0=ECB, 1=CBC, 2=CTR, 3=reserved (treated as ECB).
cfg_dir  in  1  1=encrypt, 0=decrypt.
cfg_key  in  BLOCK_W  cipher key.
cfg_iv  in  BLOCK_W  CBC IV / CTR initial counter block.
in_valid  in  1  input block valid.
in_ready  out  1  controller accepts a block.
in_data  in  BLOCK_W  input block (plaintext or ciphertext).
out_valid  out  1  output block valid.
out_ready  in  1  downstream accepts the output.
out_data  out  BLOCK_W  result block.
core_start  out  1  one-cycle start pulse to the AES core.
core_en_or_de  out  1  core direction (1=encrypt).
core_key  out  BLOCK_W  key to the core.
core_data  out  BLOCK_W  block to the core.
core_result  in  BLOCK_W  core output, valid with core_done.
core_done  in  1  core completion pulse.
busy  out  1  high in any state other than IDLE.
err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset: asynchronous, active-low; clock clk. All outputs 0. State IDLE. Key, chain, counter and saved-block registers are 0. Timeout counter is 0. in_ready is 0 while reset_n is low.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - in_ready = 1 except in any cycle where cfg_load = 1.
  - cfg_load in IDLE latches mode, dir, key and sets chain <= cfg_iv, ctr <= cfg_iv, err_timeout <= 0. It is ignored in all other states.
  - Handshake in_valid & in_ready → ISSUE. The core input is registered as follows:
    - ECB: core_data = in_data, direction = dir.
    - CBC encrypt: core_data = in_data ^ chain.
    - CBC decrypt: core_data = in_data; saved <= in_data.
    - CTR: core_data = ctr, direction forced to encrypt; saved <= in_data.
- ISSUE: core_start = 1 for exactly one cycle → WAIT. core_data, core_key and core_en_or_de are held stable from ISSUE until core_done is seen.
- WAIT: the timeout counter increments each cycle. On core_done, out_data is registered and out_valid <= 1 → HOLD:
  - ECB: core_result.
  - CBC encrypt: core_result; chain <= core_result.
  - CBC decrypt: core_result ^ chain; chain <= saved.
  - CTR: core_result ^ saved; ctr[CTR_W-1:0] <= ctr[CTR_W-1:0] + 1, wrapping mod 2^CTR_W; ctr upper bits unchanged.
- Timeout: if the counter reaches MAX_WAIT without core_done, err_timeout <= 1 (sticky) → IDLE. The block is discarded, chain and ctr are unchanged, and no out_valid is produced. Only cfg_load or reset clears err_timeout.
- HOLD: out_valid and out_data are held stable until out_ready. On out_valid & out_ready: out_valid <= 0 → IDLE. in_ready is first asserted in the cycle after the output handshake (no overlap; one block in flight).
- Latency: input handshake at cycle T, core_start at T+1, out_valid at the cycle after core_done.
- core_done outside WAIT is ignored.
- A reset mid-operation abandons the block and returns to reset state.

Test Plan:
- ECB encrypt:
  - Stimulus: cfg_key=000102030405060708090a0b0c0d0e0f, in_data=00112233445566778899aabbccddeeff.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a; core_start exactly 1 cycle.
- ECB decrypt, same key, in_data=69c4e0d86a7b0430d8cdb78070b4c55a:
  - Required: out_data=00112233445566778899aabbccddeeff.
- CBC round trip:
  - Stimulus: NIST SP800-38A F.2.1 (key 2b7e1516…, IV 000102…0f), 4 blocks encrypt.
  - Required: first out_data=7649abac8119b246cee98e9b12e9197d.
  - Then cfg_load with dir=0 and decrypt the 4 ciphertexts. Required: original plaintexts.
- CTR wrap:
  - Stimulus: cfg_iv=…00000000_ffffffff, CTR_W=32, 2 blocks.
  - Required: second core_data = …00000000_00000000, with bits above 32 unchanged; out_data = E(ctr) ^ in_data.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_data stable, in_ready=0, no second core_start; one accept after out_ready.
- Timeout and reset mid-operation:
  - Stub core that never asserts core_done. Required: err_timeout=1 at MAX_WAIT cycles after core_start, state returns to IDLE, out_valid stays 0.
  - Then cfg_load. Required: err_timeout=0.
  - reset_n low during WAIT. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR chaining controller for the iterative AES-128 core.
// Valid/ready on both sides, one block in flight, sticky completion timeout.
module aes_mode_ctrl #(
    parameter int BLOCK_W  = 128,
    parameter int CTR_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_dir,
    input  logic [BLOCK_W-1:0] cfg_key,
    input  logic [BLOCK_W-1:0] cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic               core_en_or_de,
    output logic [BLOCK_W-1:0] core_key,
    output logic [BLOCK_W-1:0] core_data,
    input  logic [BLOCK_W-1:0] core_result,
    input  logic               core_done,
    output logic               busy,
    output logic               err_timeout
);

    localparam int TW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic                 dir_q, dir_d;
    logic [BLOCK_W-1:0]   key_q, key_d;
    logic [BLOCK_W-1:0]   chain_q, chain_d;
    logic [BLOCK_W-1:0]   ctr_q, ctr_d;
    logic [BLOCK_W-1:0]   saved_q, saved_d;
    logic [BLOCK_W-1:0]   cdata_q, cdata_d;
    logic                 cdir_q, cdir_d;
    logic [BLOCK_W-1:0]   odata_q, odata_d;
    logic                 ovalid_q, ovalid_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic                 is_cbc;
    logic                 is_ctr;
    logic                 in_hs;
    logic [BLOCK_W-1:0]   ctr_inc;

    assign is_cbc = (mode_q == 2'd1);
    assign is_ctr = (mode_q == 2'd2);

    assign in_ready      = (state_q == IDLE) & ~cfg_load & reset_n;
    assign in_hs         = in_valid & in_ready;
    assign core_start    = (state_q == ISSUE);
    assign busy          = (state_q != IDLE);
    assign core_key      = key_q;
    assign core_data     = cdata_q;
    assign core_en_or_de = cdir_q;
    assign out_data      = odata_q;
    assign out_valid     = ovalid_q;
    assign err_timeout   = err_q;

    // Only the low CTR_W bits count; the nonce part above never sees a carry.
    always_comb begin
        ctr_inc = ctr_q;
        ctr_inc[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        key_d    = key_q;
        chain_d  = chain_q;
        ctr_d    = ctr_q;
        saved_d  = saved_q;
        cdata_d  = cdata_q;
        cdir_d   = cdir_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    mode_d  = cfg_mode;
                    dir_d   = cfg_dir;
                    key_d   = cfg_key;
                    chain_d = cfg_iv;
                    ctr_d   = cfg_iv;
                    err_d   = 1'b0;
                end else if (in_hs) begin
                    cdir_d  = dir_q;
                    state_d = ISSUE;
                    if (is_ctr) begin
                        cdata_d = ctr_q;
                        cdir_d  = 1'b1;
                        saved_d = in_data;
                    end else if (is_cbc && dir_q) begin
                        cdata_d = in_data ^ chain_q;
                    end else if (is_cbc) begin
                        cdata_d = in_data;
                        saved_d = in_data;
                    end else begin
                        cdata_d = in_data;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = TW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    ovalid_d = 1'b1;
                    odata_d  = core_result;
                    state_d  = HOLD;
                    if (is_ctr) begin
                        odata_d = core_result ^ saved_q;
                        ctr_d   = ctr_inc;
                    end else if (is_cbc && dir_q) begin
                        chain_d = core_result;
                    end else if (is_cbc) begin
                        odata_d = core_result ^ chain_q;
                        chain_d = saved_q;
                    end
                end else if (tmo_q >= TW'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            dir_q    <= 1'b0;
            key_q    <= '0;
            chain_q  <= '0;
            ctr_q    <= '0;
            saved_q  <= '0;
            cdata_q  <= '0;
            cdir_q   <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            key_q    <= key_d;
            chain_q  <= chain_d;
            ctr_q    <= ctr_d;
            saved_q  <= saved_d;
            cdata_q  <= cdata_d;
            cdir_q   <= cdir_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule
